// File: rtl/fir_in_ctrl.sv
// FIR input-rate job sequencer: latches rate/tail/len, flushes the rate
// stage, marks the last input and counts outputs to completion.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   start, abort            job request / cancel (abort wins outside IDLE)
//   cfg_rate/tail/len       job configuration, sampled on accepted start
//   dma_valid,in_rate_ready input handshake into the rate stage
//   out_valid, in_ready     output handshake from the rate stage
//   rate, tail, flush       rate stage controls
//   last_in                 final input sample marker
//   busy, done, err         job status
module fir_in_ctrl #(
  parameter int W_RATE = 4,
  parameter int W_TAIL = 8,
  parameter int W_LEN  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [W_RATE-1:0] cfg_rate,
  input  logic [W_TAIL-1:0] cfg_tail,
  input  logic [W_LEN-1:0]  cfg_len,
  input  logic              dma_valid,
  input  logic              in_rate_ready,
  input  logic              out_valid,
  input  logic              in_ready,
  output logic [W_RATE-1:0] rate,
  output logic [W_TAIL-1:0] tail,
  output logic              flush,
  output logic              last_in,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int WE = W_LEN + W_RATE + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_RUN,
    S_DRAIN,
    S_DONE,
    S_ABORT
  } state_t;

  state_t state, state_nx;

  logic [W_RATE-1:0] rate_q;
  logic [W_TAIL-1:0] tail_q;
  logic [W_LEN-1:0]  len_q;
  logic [WE-1:0]     exp_q;
  logic [W_LEN-1:0]  in_cnt;
  logic [WE-1:0]     out_cnt;
  logic              flush_q;
  logic              done_q;
  logic              err_q;

  logic              acc_in;
  logic              acc_out;
  logic              in_last;
  logic              out_hit;
  logic              go;
  logic              bad;
  logic [WE-1:0]     exp_new;

  assign acc_in  = dma_valid & in_rate_ready;
  assign acc_out = out_valid & in_ready;
  assign in_last = (in_cnt == len_q - W_LEN'(1));
  // Compare against the post-increment count so completion is seen
  // on the same edge that accepts the final output.
  assign out_hit = acc_out & (out_cnt + WE'(1) == exp_q);
  assign go      = (state == S_IDLE) & start & (cfg_len != '0);
  assign bad     = (state == S_IDLE) & start & (cfg_len == '0);

  // rate==0 collapses to len*1, so one expression covers both cases.
  assign exp_new = WE'(cfg_len) * (WE'(cfg_rate) + WE'(1))
                 + WE'(cfg_tail) + WE'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (go) state_nx = S_FLUSH;
      S_FLUSH: state_nx = S_RUN;
      S_RUN: begin
        if (out_hit)
          state_nx = S_DONE;
        else if (acc_in & in_last)
          state_nx = S_DRAIN;
      end
      S_DRAIN: if (out_hit) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      S_ABORT: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (abort && state != S_IDLE && state != S_ABORT)
      state_nx = S_ABORT;
  end

  always_comb begin
    busy    = (state == S_FLUSH) | (state == S_RUN) |
              (state == S_DRAIN) | (state == S_ABORT);
    last_in = (state == S_RUN) & in_last & dma_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rate_q <= '0;
      tail_q <= '0;
      len_q  <= '0;
      exp_q  <= '0;
    end else if (go) begin
      rate_q <= cfg_rate;
      tail_q <= cfg_tail;
      len_q  <= cfg_len;
      exp_q  <= exp_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt  <= '0;
      out_cnt <= '0;
    end else if (state == S_FLUSH) begin
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      if (state == S_RUN && acc_in)
        in_cnt <= in_cnt + W_LEN'(1);
      if ((state == S_RUN || state == S_DRAIN) && acc_out)
        out_cnt <= out_cnt + WE'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      flush_q <= (state_nx == S_FLUSH) | (state_nx == S_ABORT);
      done_q  <= (state_nx == S_DONE);
      err_q   <= bad;
    end
  end

  assign rate  = rate_q;
  assign tail  = tail_q;
  assign flush = flush_q;
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_fir_in_ctrl.sv
// Randomized self-checking bench for fir_in_ctrl.
// Job-level model: expected counts from the rate/tail/len arithmetic.
module tb_fir_in_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  cfg_rate = '0;
  logic [7:0]  cfg_tail = '0;
  logic [15:0] cfg_len = '0;
  logic        dma_valid = 1'b0;
  logic        in_rate_ready = 1'b0;
  logic        out_valid = 1'b0;
  logic        in_ready = 1'b0;
  logic [3:0]  rate;
  logic [7:0]  tail;
  logic        flush;
  logic        last_in;
  logic        busy;
  logic        done;
  logic        err;

  int n_chk = 0;
  int n_fail = 0;

  fir_in_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .cfg_rate     (cfg_rate),
    .cfg_tail     (cfg_tail),
    .cfg_len      (cfg_len),
    .dma_valid    (dma_valid),
    .in_rate_ready(in_rate_ready),
    .out_valid    (out_valid),
    .in_ready     (in_ready),
    .rate         (rate),
    .tail         (tail),
    .flush        (flush),
    .last_in      (last_in),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int mode, input int cyc);
    case (mode)
      0: begin
        dma_valid = 1; in_rate_ready = 1;
        out_valid = 1; in_ready = 1;
      end
      1: begin
        dma_valid = 1; in_rate_ready = cyc[0];
        out_valid = 1; in_ready = (cyc % 3) != 2;
      end
      default: begin
        dma_valid     = ($urandom % 4) != 0;
        in_rate_ready = $urandom % 2;
        out_valid     = ($urandom % 4) != 0;
        in_ready      = ($urandom % 3) != 0;
      end
    endcase
  endtask

  task automatic idle_bus();
    dma_valid = 0; in_rate_ready = 0;
    out_valid = 0; in_ready = 0;
  endtask

  task automatic run_job(input int r, input int t, input int l,
                         input int mode, input bit poke);
    int  e;
    int  ni;
    int  no;
    int  cyc;
    bit  fin;
    bit  ain;
    bit  aout;
    bit  li;
    e   = (r > 0) ? l * (r + 1) + t + 1 : l + t + 1;
    ni  = 0;
    no  = 0;
    cyc = 0;
    fin = 0;
    cfg_rate = 4'(r);
    cfg_tail = 8'(t);
    cfg_len  = 16'(l);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    // handshakes during FLUSH must be ignored
    dma_valid = 1; in_rate_ready = 1;
    out_valid = 1; in_ready = 1;
    #1;
    chk("flush_hi", flush, 1);
    chk("busy_rise", busy, 1);
    chk("rate_lat", rate, r);
    chk("tail_lat", tail, t);
    chk("last_in_flush", last_in, 0);
    @(posedge clk); #1;
    chk("flush_lo", flush, 0);
    while (!fin && cyc < 4000) begin
      drive(mode, cyc);
      if (poke && cyc == 0) begin
        start = 1;
        cfg_rate = ~4'(r);
        cfg_tail = ~8'(t);
        cfg_len = 16'd1;
      end
      #1;
      ain  = dma_valid & in_rate_ready;
      aout = out_valid & in_ready;
      li   = (ni == l - 1) && dma_valid;
      chk("last_in", last_in, li);
      chk("busy_run", busy, 1);
      chk("done_early", done, 0);
      chk("rate_hold", rate, r);
      chk("tail_hold", tail, t);
      @(posedge clk); #1;
      start = 0;
      if (ain && ni < l) ni++;
      if (aout) no++;
      if (no == e) fin = 1;
      cyc++;
    end
    idle_bus();
    if (!fin) chk("job_timeout", 0, 1);
    chk("done_hi", done, 1);
    chk("busy_lo", busy, 0);
    chk("flush_done", flush, 0);
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
    chk("busy_idle", busy, 0);
    chk("rate_idle", rate, r);
    chk("tail_idle", tail, t);
  endtask

  initial begin
    #2;
    chk("rst_rate", rate, 0);
    chk("rst_tail", tail, 0);
    chk("rst_flush", flush, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_last", last_in, 0);
    #20 rst_n = 1;
    @(posedge clk); #1;

    // bypass, upsample, backpressure
    run_job(0, 3, 5, 0, 0);
    run_job(2, 0, 4, 0, 0);
    run_job(2, 0, 4, 1, 0);

    // illegal start
    cfg_len = 0; cfg_rate = 4'd5; start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("err_hi", err, 1);
    chk("err_busy", busy, 0);
    chk("err_flush", flush, 0);
    chk("err_rate", rate, 2);
    @(posedge clk); #1;
    chk("err_pulse", err, 0);
    chk("err_busy2", busy, 0);

    // redundant start while busy
    run_job(1, 2, 3, 2, 1);

    // abort after 2 of 6 inputs
    cfg_rate = 0; cfg_tail = 0; cfg_len = 6; start = 1;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    dma_valid = 1; in_rate_ready = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    idle_bus();
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    chk("abort_flush", flush, 1);
    chk("abort_busy", busy, 1);
    chk("abort_done", done, 0);
    @(posedge clk); #1;
    chk("abort_flush_lo", flush, 0);
    chk("abort_idle", busy, 0);
    chk("abort_nodone", done, 0);
    @(posedge clk); #1;
    chk("abort_nodone2", done, 0);
    run_job(1, 1, 1, 0, 0);

    // reset in DRAIN
    cfg_rate = 3; cfg_tail = 5; cfg_len = 2; start = 1;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    dma_valid = 1; in_rate_ready = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("drain_busy", busy, 1);
    #1 rst_n = 0;
    #1;
    chk("arst_rate", rate, 0);
    chk("arst_tail", tail, 0);
    chk("arst_flush", flush, 0);
    chk("arst_last", last_in, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_err", err, 0);
    idle_bus();
    @(posedge clk); #3;
    rst_n = 1;
    @(posedge clk); #1;
    run_job(3, 5, 2, 0, 0);

    // random jobs
    for (int k = 0; k < 20; k++) begin
      run_job($urandom_range(0, 3), $urandom_range(0, 7),
              $urandom_range(1, 8), 2, k[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_in_ctrl.md
# fir_in_ctrl

Job sequencer for the FIR input rate stage. Latches one job's configuration (upsample rate, tail length, input sample count), flushes the rate stage, drives its rate/tail/flush controls, and counts accepted input samples to raise `last_in` on the final one. It then counts samples delivered to the compute stage until the job's output count is reached, and reports completion. Sits between the FIR register/control block and the input rate stage.

## Interface
Parameters:
- `W_RATE`, 4, width of the rate field.
- `W_TAIL`, 8, width of the tail field.
- `W_LEN`, 16, width of the input sample count.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; one clock, asynchronous and active-low.
- `start`  in  1  job request, qualified in IDLE only.
- `abort`  in  1  cancel the current job; has priority over `start`.
- `cfg_rate`  in  W_RATE  upsample control: 0 = bypass, R>0 inserts R zeros after each input sample.
- `cfg_tail`  in  W_TAIL  tail zeros minus one.
- `cfg_len`  in  W_LEN  number of input samples; 0 is illegal.
- `dma_valid`  in  1  DMA sample offered to the rate stage.
- `in_rate_ready`  in  1  rate stage accepts the DMA sample.
- `out_valid`  in  1  rate stage output valid.
- `in_ready`  in  1  compute stage pops the rate stage output.
- `rate`  out  W_RATE  to rate stage.
- `tail`  out  W_TAIL  to rate stage.
- `flush`  out  1  to rate stage.
- `last_in`  out  1  to rate stage; marks the final input sample.
- `busy`  out  1  high from acceptance until DONE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse: start rejected because `cfg_len`==0.

## Operation
- Accepted input: `acc_in = dma_valid & in_rate_ready`.
- Delivered output: `acc_out = out_valid & in_ready`.
- Expected output count: `exp_out = cfg_len*(cfg_rate+1) + cfg_tail + 1` when `cfg_rate`>0, and `cfg_len + cfg_tail + 1` when `cfg_rate`==0.
  - Computed at start in `W_LEN+W_RATE+1` bits, unsigned, no overflow possible.
- States:
  - IDLE
    - `start` & `cfg_len`!=0: latch rate, tail, len and `exp_out`; go to FLUSH.
    - `start` & `cfg_len`==0: pulse `err` and stay in IDLE.
  - FLUSH: `flush`=1 for exactly one cycle; clear both counters; go to RUN.
  - RUN
    - `in_cnt` increments on `acc_in`.
    - `last_in` is combinational: `(in_cnt == len-1) & dma_valid`. It is only meaningful when `acc_in`.
    - On `acc_in` with `in_cnt == len-1`, go to DRAIN.
  - DRAIN: after the final input; output counting continues; go to DONE when the output count reaches `exp_out`.
  - DONE: `done`=1 for one cycle; go to IDLE.
- Output counting:
  - `out_cnt` increments on `acc_out` in both RUN and DRAIN.
  - Completion is checked in RUN as well, so a job whose last output coincides with the last input still completes.
  - `acc_out` during IDLE, FLUSH or DONE is ignored.
- `rate` and `tail` are driven from the latched registers. They are stable from FLUSH through DONE and hold their last values in IDLE.
- `abort` in any non-IDLE state: go to FLUSH-ABORT, which asserts `flush` for one cycle, then go to IDLE with no `done` pulse. `abort` in IDLE has no effect.
- `start` outside IDLE is ignored.

## Timing
- Reset values: state=IDLE; `rate`=0, `tail`=0, `flush`=0, `last_in`=0, `busy`=0, `done`=0, `err`=0; all counters 0.
- `start` sampled at edge N → `flush` high in cycle N+1 → RUN from N+2. `busy` rises at N+1.
- `last_in` has zero latency relative to `dma_valid` in the same cycle.
- `done` is asserted the cycle after the edge where `out_cnt+acc_out` reaches `exp_out`. `busy` drops in the same cycle `done` is high.
- If `acc_in` and `acc_out` occur in the same cycle, both counters update.
- Reset asserted mid-job returns the block to IDLE immediately with all outputs 0. No flush is issued; the rate stage is reset by the same `rst_n`.
- `flush`, `done` and `err` are registered outputs. `busy` is decoded from state.

## Test plan
- Bypass job: `cfg_rate`=0, `cfg_tail`=3, `cfg_len`=5, DMA and compute always ready → `flush` for 1 cycle, `last_in` on the 5th accepted input, `done` after exactly 9 outputs.
- Upsample job: `cfg_rate`=2, `cfg_tail`=0, `cfg_len`=4 → `exp_out`=13; `done` only after the 13th `acc_out`; `rate`=2 is held stable while `busy`.
- Backpressure: as in the upsample job, but `in_rate_ready` toggles every cycle and `in_ready` stalls 1 cycle in 3 → same counts; `last_in` is never asserted with `dma_valid` low.
- Illegal and redundant starts: `start` with `cfg_len`=0 → `err` pulse, `busy` stays 0; `start` while busy → ignored, latched config unchanged.
- Abort: `abort` in RUN after 2 of 6 inputs → one `flush` pulse, return to IDLE, no `done`; a following job with `cfg_len`=1, `cfg_rate`=1, `cfg_tail`=1 completes after 4 outputs.
- Reset mid-DRAIN: assert `rst_n`=0 → all outputs 0 asynchronously; after release, the next job runs normally.
